data_cache_system: RTL and testbench
====================================

# data_cache_system

Data-memory subsystem for the single-cycle RV32F core. It accepts one load or store per request from the core's data port. It serves loads from a direct-mapped, write-through, no-write-allocate cache backed by a 4 KiB word-organized main memory with fixed latency. It asserts `stall` to freeze the core while main memory is busy.

## Interface
Parameters:
- `MEM_LAT`, default 4: main-memory access latency in cycles.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
  - Clears all valid bits, FSM and counter.
  - Does not clear main-memory or cache data arrays.
- `Mem_Write`  in  1: store request, held by the core until `stall` is low.
- `Mem_read`  in  1: load request, held by the core until `stall` is low.
- `stall`  out  1: core must hold PC and request while high.
- `a_data_mem`  in  32: byte address.
- `w_data_mem`  in  32: store data.
- `r_data_mem`  out  32: load data.

## Operation
Address decoding:
- Bits [1:0] and [31:12] are ignored; addresses alias modulo 4 KiB.
- offset = a[3:2]; index = a[8:4]; tag = a[11:9].

Storage:
- Cache: 32 lines × 4 words, each line with a valid bit and a 3-bit tag.
- Main memory: 1024 × 32-bit words, zero-initialised at time 0.
- hit = valid[index] && tag match.

FSM states: IDLE, FILL, WRITE, WDONE. Counter width is clog2(`MEM_LAT`).

IDLE:
- `Mem_Write` (has priority over `Mem_read`): `stall`=1; go to WRITE with counter=0.
- `Mem_read` && hit: `stall`=0; `r_data_mem` = cache word at (index, offset), combinational.
- `Mem_read` && miss: `stall`=1; go to FILL with counter=0.
- No request: `stall`=0.

FILL:
- `stall`=1; counter increments each cycle.
- On the edge ending the `MEM_LAT`-th FILL cycle:
  - Load all 4 words of block {tag, index} from main memory into the line.
  - Set valid and tag; go to IDLE.
- IDLE then sees a hit and releases `stall`.

WRITE:
- `stall`=1; counter increments each cycle.
- On the edge ending the (`MEM_LAT`-1)-th WRITE cycle:
  - Write `w_data_mem` to main memory.
  - If hit, also update the cache word. On a miss, do not allocate.
  - Go to WDONE.

WDONE:
- `stall`=0; the core retires the store on this edge.
- Requests are ignored; always go to IDLE.

Other rules:
- `r_data_mem` = 0 whenever not (IDLE && `Mem_read` && hit && !`Mem_Write`).
- Address and data are sampled from the ports, which the core holds stable while `stall`=1.

## Timing
Reset values: `stall`=0, `r_data_mem`=0, state IDLE, all valid bits 0. `reset` takes effect immediately, not at the next edge.

Latencies with `MEM_LAT`=4:
- Read hit: 0 stall cycles.
- Read miss: 5 stall cycles (detect cycle + 4 FILL cycles), then data is valid with `stall`=0.
- Write (hit or miss): 4 stall cycles, then 1 WDONE cycle with `stall`=0.
- A read following a write completes in the cycle after WDONE.

`stall` is combinational from state, requests and hit. It may rise in the same cycle a request appears.

Reset during FILL or WRITE:
- Abort the operation; `stall` drops asynchronously.
- Memory is not written and no line is filled.

Back-to-back misses to lines with the same index evict each other; there is no replacement choice.

## Test plan
- Reset, then read 0x000: `stall` high exactly 5 cycles, then `r_data_mem`=0x00000000. Read 0x004 next: 0 stall cycles, data 0.
- Write 0x010 = 0xDEADBEEF (cold): 4 stall cycles, then WDONE. Read 0x010: miss (no allocate), 5 stall cycles, data 0xDEADBEEF. Read 0x014: hit, no stall.
- Write hit: read 0x010 (fills line), write 0x010 = 0x12345678, read 0x010: 0 stall cycles, returns 0x12345678; main memory also holds 0x12345678.
- Conflict: read 0x000, read 0x200 (same index 0, tag 1, miss), read 0x000 again: misses with 5 stall cycles. Read 0x1000 aliases 0x000.
- Assert `Mem_read` and `Mem_Write` together at 0x020 with data 0xA5A5A5A5: treated as a write (4 stall cycles); a later read of 0x020 returns 0xA5A5A5A5.
- Assert `reset` in the 2nd FILL cycle of a read of 0x040: `stall`=0 immediately. After release, the read of 0x040 misses again (5 stall cycles).

Source files
------------

// File: rtl/data_cache_system.sv
// Data-memory subsystem: direct-mapped, write-through, no-write-allocate cache
// in front of a 4 KiB fixed-latency main memory, stalling the core while busy.
module data_cache_system #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write,
  input  logic        Mem_read,
  output logic        stall,
  input  logic [31:0] a_data_mem,
  input  logic [31:0] w_data_mem,
  output logic [31:0] r_data_mem
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(MEM_LAT - 2);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      valid;
  logic             fill_en, wr_en, hit;

  logic [1:0] offset;
  logic [4:0] index;
  logic [2:0] tag;

  logic [31:0] main_mem   [0:1023] = '{default: '0};
  logic [31:0] cache_data [0:31][0:3];
  logic [2:0]  cache_tag  [0:31];

  logic unused_addr;
  assign unused_addr = ^{a_data_mem[31:12], a_data_mem[1:0]};

  assign offset = a_data_mem[3:2];
  assign index  = a_data_mem[8:4];
  assign tag    = a_data_mem[11:9];
  assign hit    = valid[index] && (cache_tag[index] == tag);

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    r_data_mem = '0;
    fill_en    = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        // Stores win over loads when both are requested together.
        if (Mem_Write) begin
          stall      = 1'b1;
          next_state = WRITE;
        end else if (Mem_read) begin
          if (hit) begin
            r_data_mem = cache_data[index][offset];
          end else begin
            stall      = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        stall = 1'b1;
        if (cnt == FILL_LAST) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (cnt == WRITE_LAST) begin
          wr_en      = 1'b1;
          next_state = WDONE;
        end
      end
      WDONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
    end else begin
      state <= next_state;
      cnt   <= (state == IDLE) ? '0 : cnt + CNT_W'(1);
      if (fill_en) valid[index] <= 1'b1;
    end
  end

  // Storage arrays keep their contents across reset; only valid bits clear.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      for (int k = 0; k < 4; k++)
        cache_data[index][k] <= main_mem[{tag, index, k[1:0]}];
      cache_tag[index] <= tag;
    end
    if (wr_en) begin
      main_mem[a_data_mem[11:2]] <= w_data_mem;
      if (hit) cache_data[index][offset] <= w_data_mem;
    end
  end

endmodule

// File: tb/tb_data_cache_system.sv
// Scoreboard bench for data_cache_system: directed scenarios plus random traffic
// checked against a block-level cache/memory reference model.
module tb_data_cache_system;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Write, Mem_read, stall;
  logic [31:0] a_data_mem, w_data_mem, r_data_mem;

  always #5 clk = ~clk;

  data_cache_system #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Mem_Write(Mem_Write), .Mem_read(Mem_read),
    .stall(stall), .a_data_mem(a_data_mem), .w_data_mem(w_data_mem),
    .r_data_mem(r_data_mem)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:1023];
  int          line_blk [0:31];
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 32; i++) line_blk[i] = -1;
  endtask

  // Cache is write-through with update on hit, so a valid line always mirrors
  // memory: a load returns ref_mem, and only presence decides the latency.
  task automatic model_issue(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int word, blk, idx;
    exp_t e;
    word = int'(addr[11:2]);
    blk  = int'(addr[11:4]);
    idx  = int'(addr[8:4]);
    if (wr) begin
      ref_mem[word] = data;
      e = '{is_wr: 1'b1, data: 32'h0, stalls: LAT};
    end else begin
      e = '{is_wr: 1'b0, data: ref_mem[word],
            stalls: (line_blk[idx] == blk) ? 0 : LAT + 1};
      line_blk[idx] = blk;
    end
    sb.push_back(e);
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
    int n;
    model_issue(wr, addr, data);
    Mem_Write  = wr;
    Mem_read   = rd;
    a_data_mem = addr;
    w_data_mem = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 40);
    if (stall) begin
      checks++;
      errors++;
      $display("FAIL timeout addr %h stall still %b after %0d cycles", addr, stall, n);
      finish_now();
    end
    @(posedge clk);
    #1;
    Mem_Write = 1'b0;
    Mem_read  = 1'b0;
  endtask

  // Load that gets reset in its second FILL cycle; nothing is expected from it.
  task automatic abort_read(input logic [31:0] addr);
    Mem_read   = 1'b1;
    a_data_mem = addr;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    Mem_read = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall}, 32'h0);
    chk("abort_rdata", r_data_mem, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_invalidate();
  endtask

  // Monitor: counts stall cycles of the live request and scores it on release.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_cnt = 0;
    end else if (Mem_read || Mem_Write) begin
      if (stall) begin
        stall_cnt++;
      end else begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected completion addr %h got %h want none", a_data_mem, r_data_mem);
        end else begin
          e = sb.pop_front();
          chk(e.is_wr ? "wr_stalls" : "rd_stalls", stall_cnt, e.stalls);
          chk(e.is_wr ? "wr_rdata" : "rd_data", r_data_mem, e.data);
        end
        stall_cnt = 0;
      end
    end else begin
      chk("idle_stall", {31'b0, stall}, 32'h0);
      chk("idle_rdata", r_data_mem, 32'h0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    bit          wr, rd;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    model_invalidate();
    reset = 1'b1;
    Mem_Write = 1'b0;
    Mem_read = 1'b0;
    a_data_mem = '0;
    w_data_mem = '0;
    #1;
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_rdata", r_data_mem, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(0, 1, 32'h000, 32'h0);
    issue(0, 1, 32'h004, 32'h0);
    issue(1, 0, 32'h010, 32'hDEADBEEF);
    issue(0, 1, 32'h010, 32'h0);
    issue(0, 1, 32'h014, 32'h0);
    issue(0, 1, 32'h010, 32'h0);
    issue(1, 0, 32'h010, 32'h12345678);
    issue(0, 1, 32'h010, 32'h0);
    issue(0, 1, 32'h210, 32'h0);
    issue(0, 1, 32'h010, 32'h0);
    issue(0, 1, 32'h000, 32'h0);
    issue(0, 1, 32'h200, 32'h0);
    issue(0, 1, 32'h000, 32'h0);
    issue(0, 1, 32'h1000, 32'h0);
    issue(1, 1, 32'h020, 32'hA5A5A5A5);
    issue(0, 1, 32'h020, 32'h0);
    abort_read(32'h040);
    issue(0, 1, 32'h040, 32'h0);

    for (int n = 0; n < 300; n++) begin
      addr       = $urandom;
      addr[11:9] = 3'($urandom_range(0, 3));
      addr[8:4]  = 5'($urandom_range(0, 3));
      wr = ($urandom_range(0, 2) == 0);
      rd = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
      issue(wr, rd, addr, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    finish_now();
  end

endmodule
